instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Fetch/decode/sequencing front end for the 16-bit processor. Fetches 16-bit
//  instructions from instruction memory over a req/valid handshake, splits them
//  into the op_code/rd/rs/rt/shamt/constant fields the register-file datapath
//  consumes, and strobes execute and writeback. Resolves J-type opcodes
//  (jump, branch on SR flags, halt) locally against the datapath status register.
// PARAMETERS
//  PC_W        8   program counter / instruction address width (bits)
//  EXEC_CYCLES 1   cycles spent in EXEC before WB (>=1), covers ALU settle time
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      synchronous active-low reset
//  imem_req    out  1      fetch request, held high until imem_valid
//  imem_addr   out  PC_W   fetch address (= pc while imem_req high)
//  imem_rdata  in   16     instruction word, sampled when imem_valid=1 in FETCH
//  imem_valid  in   1      instruction word valid; ignored outside FETCH
//  sr          in   16     datapath status: [3]=zero [2]=negative [1]=carry [0]=ovf
//  op_code     out  4      instr[15:12]
//  rd_index    out  3      instr[11:9]
//  rs_index    out  3      instr[8:6]
//  rt_index    out  3      instr[5:3], R-type only, else 0
//  shamt       out  3      instr[2:0], R-type only, else 0
//  constant    out  6      instr[5:0], I-type only, else 0
//  exec_en     out  1      one strobe per EXEC cycle
//  wb_en       out  1      one-cycle writeback strobe (R/I types only)
//  pc          out  PC_W   current program counter
//  halted      out  1      high once HALT has been decoded
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=FETCH, pc=0, IR=0, all field outputs 0,
//   imem_req/exec_en/wb_en/halted=0; imem_req rises the first cycle after reset.
//  Reset overrides every state, including mid-handshake, EXEC or HALT.
//  Opcode classes: 0-7 R-type, 8-11 I-type, 12 JMP, 13 JZ (sr[3]), 14 JN (sr[2]),
//   15 HALT. Jump target = instr[11:0] truncated/zero-extended to PC_W.
//  FSM: FETCH -> DECODE -> EXEC (xEXEC_CYCLES) -> WB -> FETCH; DECODE -> HALT on op 15.
//   FETCH: imem_req=1, imem_addr=pc; stay until imem_valid=1, then IR<=imem_rdata.
//   DECODE: field outputs registered from IR in this cycle; stable until next DECODE.
//    J-type fields: rd/rs/rt/shamt/constant all 0.
//   EXEC: exec_en=1 every EXEC cycle; counter reloads each instruction.
//   WB: R/I: wb_en=1, pc<=pc+1. JMP: pc<=target. JZ/JN: pc<=target if flag set in
//    sr sampled this cycle, else pc+1. wb_en=0 for all J-type.
//   HALT: halted=1, no requests, outputs frozen; exit only by reset.
//  pc+1 wraps modulo 2^PC_W (all-ones -> 0) without a flag.
//  Minimum latency per instruction = 1 (FETCH, imem_valid same cycle) + 1 + EXEC_CYCLES + 1.
//  imem_valid asserted outside FETCH: ignored, IR unchanged.
//  exec_en and wb_en never high in the same cycle; imem_req low outside FETCH.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with imem_valid=1 -> pc=0, all outputs 0, no req.
//  2 R-type 0x1A5B fetched at pc=0, valid 2 cycles late -> op=1 rd=5 rs=1 rt=3
//    shamt=3 const=0; one exec_en, one wb_en; pc=1 at next FETCH.
//  3 I-type 0x8A3F -> op=8 rd=5 rs=0 const=0x3F rt=0 shamt=0; wb_en pulses once.
//  4 JZ 0xD020 with sr[3]=1 -> pc=0x20, wb_en=0; repeat with sr=0 -> pc=old+1.
//  5 pc=0xFF (PC_W=8) R-type -> pc wraps to 0x00; HALT 0xF000 -> halted=1,
//    imem_req stays 0 for 10 cycles.
//  6 rst_n=0 during EXEC of EXEC_CYCLES=3 -> next cycle state FETCH, pc=0, exec_en=0.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and the memory (slave).
interface instr_sequencer_if #(
  parameter int unsigned PC_W = 8
) ();
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/sequencing front end: fetches 16-bit instructions, decodes register fields,
// strobes execute/writeback and resolves jumps, conditional branches and halt locally.
module instr_sequencer #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_sequencer_if.master   imem,
  input  logic [15:0]         sr,
  output logic [3:0]          op_code,
  output logic [2:0]          rd_index,
  output logic [2:0]          rs_index,
  output logic [2:0]          rt_index,
  output logic [2:0]          shamt,
  output logic [5:0]          constant,
  output logic                exec_en,
  output logic                wb_en,
  output logic [PC_W-1:0]     pc,
  output logic                halted
);

  localparam int unsigned CntW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StWb, StHalt} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [3:0]      op_code_q, op_code_d;
  logic [2:0]      rd_q, rd_d, rs_q, rs_d, rt_q, rt_d, shamt_q, shamt_d;
  logic [5:0]      constant_q, constant_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            halted_q, halted_d;
  logic            fetch_req;

  logic            ir_rtype, ir_itype, ir_jtype;
  logic [PC_W+11:0] target_ext;
  logic [PC_W-1:0] jmp_target, pc_inc;
  logic            unused_sr;

  assign ir_rtype   = ~ir_q[15];
  assign ir_itype   = (ir_q[15:14] == 2'b10);
  assign ir_jtype   = (ir_q[15:14] == 2'b11);
  assign target_ext = {{PC_W{1'b0}}, ir_q[11:0]};
  assign jmp_target = target_ext[PC_W-1:0];
  assign pc_inc     = pc_q + PC_W'(1);
  assign unused_sr  = ^{sr[15:4], sr[1:0]};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    op_code_d  = op_code_q;
    rd_d       = rd_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    shamt_d    = shamt_q;
    constant_d = constant_q;
    cnt_d      = cnt_q;
    halted_d   = halted_q;
    fetch_req  = 1'b0;
    exec_en    = 1'b0;
    wb_en      = 1'b0;

    unique case (state_q)
      StFetch: begin
        fetch_req = 1'b1;
        if (imem.imem_valid) begin
          ir_d    = imem.imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        op_code_d  = ir_q[15:12];
        rd_d       = ir_jtype ? 3'd0 : ir_q[11:9];
        rs_d       = ir_jtype ? 3'd0 : ir_q[8:6];
        rt_d       = ir_rtype ? ir_q[5:3] : 3'd0;
        shamt_d    = ir_rtype ? ir_q[2:0] : 3'd0;
        constant_d = ir_itype ? ir_q[5:0] : 6'd0;
        if (ir_q[15:12] == 4'hF) begin
          halted_d = 1'b1;
          state_d  = StHalt;
        end else begin
          cnt_d   = CntW'(EXEC_CYCLES - 1);
          state_d = StExec;
        end
      end
      StExec: begin
        exec_en = 1'b1;
        if (cnt_q == '0) begin
          state_d = StWb;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWb: begin
        wb_en   = ~op_code_q[3] | ~op_code_q[2];
        state_d = StFetch;
        case (op_code_q)
          4'hC:    pc_d = jmp_target;
          4'hD:    pc_d = sr[3] ? jmp_target : pc_inc;
          4'hE:    pc_d = sr[2] ? jmp_target : pc_inc;
          default: pc_d = pc_inc;
        endcase
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pc_q       <= '0;
      ir_q       <= '0;
      op_code_q  <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      shamt_q    <= '0;
      constant_q <= '0;
      cnt_q      <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      op_code_q  <= op_code_d;
      rd_q       <= rd_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      shamt_q    <= shamt_d;
      constant_q <= constant_d;
      cnt_q      <= cnt_d;
      halted_q   <= halted_d;
    end
  end

  // The state register already reads FETCH while reset is held; keep the request quiet until
  // reset is released.
  assign imem.imem_req  = fetch_req & rst_n;
  assign imem.imem_addr = pc_q;

  assign op_code  = op_code_q;
  assign rd_index = rd_q;
  assign rs_index = rs_q;
  assign rt_index = rt_q;
  assign shamt    = shamt_q;
  assign constant = constant_q;
  assign pc       = pc_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: randomized instruction stream against a
// behavioural per-instruction model of fields, strobes, latency and next pc.
module tb_instr_sequencer;

  localparam int unsigned PC_W        = 8;
  localparam int unsigned EXEC_CYCLES = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [15:0]     sr;
  logic [3:0]      op_code;
  logic [2:0]      rd_index, rs_index, rt_index, shamt;
  logic [5:0]      constant;
  logic            exec_en, wb_en, halted;
  logic [PC_W-1:0] pc;

  int              n_checks = 0;
  int              n_fail   = 0;
  int              m_pc     = 0;

  instr_sequencer_if #(.PC_W(PC_W)) imem ();

  instr_sequencer #(
    .PC_W        (PC_W),
    .EXEC_CYCLES (EXEC_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .imem     (imem),
    .sr       (sr),
    .op_code  (op_code),
    .rd_index (rd_index),
    .rs_index (rs_index),
    .rt_index (rt_index),
    .shamt    (shamt),
    .constant (constant),
    .exec_en  (exec_en),
    .wb_en    (wb_en),
    .pc       (pc),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Feed one instruction and follow it through to the next fetch (or halt).
  task automatic run_instr(input logic [15:0] instr, input int delay, input logic [15:0] srv,
                           input bit noise);
    int   op, e_rd, e_rs, e_rt, e_sh, e_c, e_wb, e_exec, e_cyc, e_pc, target;
    bit   is_halt, taken, overlap;
    int   n_exec, n_wb, cyc;
    op      = int'(instr[15:12]);
    target  = int'(instr[11:0]) % (1 << PC_W);
    e_rd = 0; e_rs = 0; e_rt = 0; e_sh = 0; e_c = 0; e_wb = 0;
    is_halt = (op == 15);
    e_exec  = is_halt ? 0 : EXEC_CYCLES;
    e_cyc   = is_halt ? 2 : EXEC_CYCLES + 3;
    e_pc    = (m_pc + 1) % (1 << PC_W);
    if (op < 8) begin
      e_rd = int'(instr[11:9]); e_rs = int'(instr[8:6]);
      e_rt = int'(instr[5:3]);  e_sh = int'(instr[2:0]); e_wb = 1;
    end else if (op < 12) begin
      e_rd = int'(instr[11:9]); e_rs = int'(instr[8:6]); e_c = int'(instr[5:0]); e_wb = 1;
    end else if (op < 15) begin
      taken = (op == 12) || (op == 13 && srv[3]) || (op == 14 && srv[2]);
      if (taken) e_pc = target;
    end else begin
      e_pc = m_pc;
    end

    cyc = 0;
    while (imem.imem_req !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (imem.imem_req !== 1'b1 || int'(imem.imem_addr) != m_pc || int'(pc) != m_pc) begin
      n_fail++;
      $display("FAIL fetch_start: req=%b addr=%0h pc=%0h, required req=1 addr=pc=%0h",
               imem.imem_req, imem.imem_addr, pc, m_pc);
    end

    sr = srv;
    for (int i = 0; i < delay; i++) begin
      imem.imem_valid = 1'b0;
      imem.imem_rdata = 16'($urandom);
      @(negedge clk);
      n_checks++;
      if (imem.imem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL req_hold: req=%b, required 1 while waiting for valid", imem.imem_req);
      end
    end
    imem.imem_valid = 1'b1;
    imem.imem_rdata = instr;
    @(negedge clk);

    n_exec = 0; n_wb = 0; cyc = 1; overlap = 1'b0;
    while (cyc < 40) begin
      if (imem.imem_req === 1'b1 || halted === 1'b1) break;
      if (exec_en === 1'b1) n_exec++;
      if (wb_en === 1'b1) n_wb++;
      if (exec_en === 1'b1 && wb_en === 1'b1) overlap = 1'b1;
      imem.imem_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      imem.imem_rdata = 16'($urandom);
      @(negedge clk);
      cyc++;
    end
    imem.imem_valid = 1'b0;

    n_checks++;
    if (cyc != e_cyc || overlap) begin
      n_fail++;
      $display("FAIL latency %h: cycles=%0d overlap=%b, required cycles=%0d overlap=0",
               instr, cyc, overlap, e_cyc);
    end
    n_checks++;
    if (n_exec != e_exec || n_wb != e_wb) begin
      n_fail++;
      $display("FAIL strobes %h: exec=%0d wb=%0d, required exec=%0d wb=%0d",
               instr, n_exec, n_wb, e_exec, e_wb);
    end
    n_checks++;
    if (int'(op_code) != op || int'(rd_index) != e_rd || int'(rs_index) != e_rs ||
        int'(rt_index) != e_rt || int'(shamt) != e_sh || int'(constant) != e_c) begin
      n_fail++;
      $display("FAIL fields %h: op=%0d rd=%0d rs=%0d rt=%0d sh=%0d c=%0h, required %0d %0d %0d %0d %0d %0h",
               instr, op_code, rd_index, rs_index, rt_index, shamt, constant,
               op, e_rd, e_rs, e_rt, e_sh, e_c);
    end
    n_checks++;
    if (int'(pc) != e_pc || halted !== is_halt || (!is_halt && int'(imem.imem_addr) != e_pc)) begin
      n_fail++;
      $display("FAIL next_pc %h: pc=%0h addr=%0h halted=%b, required pc=%0h halted=%b",
               instr, pc, imem.imem_addr, halted, e_pc, is_halt);
    end
    m_pc = e_pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sr    = 16'hFFFF;
    imem.imem_valid = 1'b1;
    imem.imem_rdata = 16'h1A5B;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (imem.imem_req !== 1'b0 || pc !== '0 || exec_en !== 1'b0 || wb_en !== 1'b0 ||
          halted !== 1'b0 || op_code !== 4'd0 || rd_index !== 3'd0 || rs_index !== 3'd0 ||
          rt_index !== 3'd0 || shamt !== 3'd0 || constant !== 6'd0) begin
        n_fail++;
        $display("FAIL reset_state: req=%b pc=%0h exec=%b wb=%b halted=%b op=%0h, required all 0",
                 imem.imem_req, pc, exec_en, wb_en, halted, op_code);
      end
    end
    rst_n = 1'b1;
    imem.imem_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_release: req=%b addr=%0h, required req=1 addr=0",
               imem.imem_req, imem.imem_addr);
    end
    m_pc = 0;
  endtask

  task automatic test_rtype();
    run_instr(16'h1A5B, 2, 16'h0000, 1'b0);
  endtask

  task automatic test_itype();
    run_instr(16'h8A3F, 0, 16'($urandom), 1'b1);
  endtask

  task automatic test_jumps();
    run_instr(16'hD020, 1, 16'h0008, 1'b0);  // JZ taken
    run_instr(16'hD020, 0, 16'h0000, 1'b0);  // JZ not taken
    run_instr(16'hE0A0, 0, 16'h0004, 1'b1);  // JN taken
    run_instr(16'hE0A0, 2, 16'hFFFB, 1'b1);  // JN not taken
    run_instr(16'hC7FF, 0, 16'h0000, 1'b0);  // JMP, target truncated to 0xFF
  endtask

  task automatic test_wrap();
    run_instr({1'b0, 15'($urandom)}, 1, 16'($urandom), 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_instr({4'($urandom_range(0, 14)), 12'($urandom)}, $urandom_range(0, 3),
                16'($urandom), 1'b1);
    end
  endtask

  task automatic test_halt();
    run_instr(16'hF000, 0, 16'h0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      imem.imem_valid = 1'($urandom_range(0, 1));
      imem.imem_rdata = 16'($urandom);
      @(negedge clk);
      n_checks++;
      if (imem.imem_req !== 1'b0 || halted !== 1'b1 || exec_en !== 1'b0 || wb_en !== 1'b0 ||
          int'(pc) != m_pc) begin
        n_fail++;
        $display("FAIL halt_hold: req=%b halted=%b exec=%b wb=%b pc=%0h, required 0 1 0 0 %0h",
                 imem.imem_req, halted, exec_en, wb_en, pc, m_pc);
      end
    end
    imem.imem_valid = 1'b0;
  endtask

  task automatic test_reset_exec();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_pc = 0;
    n_checks++;
    if (halted !== 1'b0 || imem.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_exit: halted=%b req=%b, required halted=0 req=1", halted, imem.imem_req);
    end
    run_instr(16'h2123, 0, 16'h0000, 1'b0);
    imem.imem_valid = 1'b1;
    imem.imem_rdata = 16'h3456;
    @(negedge clk);  // decode
    imem.imem_valid = 1'b0;
    @(negedge clk);  // first exec cycle
    @(negedge clk);  // second exec cycle
    n_checks++;
    if (exec_en !== 1'b1) begin
      n_fail++;
      $display("FAIL exec_mid: exec_en=%b, required 1", exec_en);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (exec_en !== 1'b0 || pc !== '0 || imem.imem_req !== 1'b0 || op_code !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_in_exec: exec=%b pc=%0h req=%b op=%0h, required 0 0 0 0",
               exec_en, pc, imem.imem_req, op_code);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== '0 || exec_en !== 1'b0) begin
      n_fail++;
      $display("FAIL refetch: req=%b addr=%0h exec=%b, required 1 0 0",
               imem.imem_req, imem.imem_addr, exec_en);
    end
    m_pc = 0;
    run_instr(16'h9C41, 1, 16'h0000, 1'b1);
  endtask

  initial begin
    imem.imem_valid = 1'b0;
    imem.imem_rdata = 16'h0000;
    test_reset();
    test_rtype();
    test_itype();
    test_jumps();
    test_wrap();
    test_random();
    test_halt();
    test_reset_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
